// File: rtl/flow_pulse_meter.sv
// flow_pulse_meter: counts synchronised rising edges of a hall-effect flow
// sensor over back-to-back GATE_CYCLES windows and publishes a saturated
// 4-bit rate code with a one-cycle valid strobe.
// Build option: define FLOW_PULSE_AVERAGE_EN to publish the rounded mean of
// the current and previous window results instead of the raw result.
module flow_pulse_meter #(
  parameter int GATE_CYCLES = 1000,
  parameter int SYNC_STAGES = 2,
  parameter int RATE_SHIFT  = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sensor_pulse,
  input  logic       enable,
  output logic [3:0] flow_rate,
  output logic       rate_valid,
  output logic       overflow
);

  localparam int            TW     = (GATE_CYCLES > 2) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(GATE_CYCLES - 1);
  localparam int            WW     = $clog2(SYNC_STAGES + 1) + 1;
  localparam logic [WW-1:0] W_LAST = WW'(SYNC_STAGES);

  typedef enum logic [1:0] {
    WARM = 2'd0,
    IDLE = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t                 state_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_out;
  logic                   edge_q;
  logic                   pulse_edge;
  logic [WW-1:0]          warm_q;
  logic [TW-1:0]          timer_q;
  logic [15:0]            count_q;

  logic [16:0]            win_sum;
  logic [16:0]            scaled;
  logic                   cur_ovf;
  logic [3:0]             cur;
  logic [3:0]             new_rate;
  logic                   terminal;

  // Sensor synchroniser: shift register, oldest stage is the clean sample
  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], sensor_pulse};
  end

  assign sync_out = sync_q[SYNC_STAGES-1];

  // Edge register follows the synchronised level in every state, so a level
  // that is already high when RUN begins never looks like a fresh edge
  always_ff @(posedge clk) begin
    if (rst) edge_q <= 1'b0;
    else     edge_q <= sync_out;
  end

  assign pulse_edge = sync_out & ~edge_q;
  assign terminal   = (state_q == RUN) && enable && (timer_q == T_LAST);

  // Closing count includes an edge landing on the terminal cycle; 17 bits so
  // a saturated counter plus that edge cannot wrap
  always_comb begin
    win_sum = {1'b0, count_q} + {16'd0, pulse_edge};
    scaled  = win_sum >> RATE_SHIFT;
    cur_ovf = (scaled > 17'd15);
    cur     = cur_ovf ? 4'd15 : scaled[3:0];
  end

`ifdef FLOW_PULSE_AVERAGE_EN
  logic [3:0] prev_q;
  logic       first_q;
  logic [3:0] prev_sel;
  logic [4:0] avg_sum;

  // First window after entering RUN averages against itself
  always_comb begin
    prev_sel = first_q ? cur : prev_q;
    avg_sum  = {1'b0, cur} + {1'b0, prev_sel} + 5'd1;
    new_rate = avg_sum[4:1];
  end

  // History register: cleared outside RUN, updated on every closed window
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q  <= 4'd0;
      first_q <= 1'b1;
    end else if (state_q != RUN) begin
      first_q <= 1'b1;
    end else if (terminal) begin
      prev_q  <= cur;
      first_q <= 1'b0;
    end
  end
`else
  assign new_rate = cur;
`endif

  // Control FSM with window timer, edge counter and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= WARM;
      warm_q     <= '0;
      timer_q    <= '0;
      count_q    <= 16'd0;
      flow_rate  <= 4'd0;
      rate_valid <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      rate_valid <= 1'b0;
      case (state_q)
        WARM: begin
          timer_q <= '0;
          count_q <= 16'd0;
          if (warm_q == W_LAST) state_q <= IDLE;
          else                  warm_q  <= warm_q + 1'b1;
        end
        IDLE: begin
          timer_q <= '0;
          count_q <= 16'd0;
          if (enable) state_q <= RUN;
        end
        RUN: begin
          if (!enable) begin
            // aborted window: partial count dropped, outputs hold
            state_q <= IDLE;
            timer_q <= '0;
            count_q <= 16'd0;
          end else if (timer_q == T_LAST) begin
            timer_q    <= '0;
            count_q    <= 16'd0;
            flow_rate  <= new_rate;
            overflow   <= cur_ovf;
            rate_valid <= 1'b1;
          end else begin
            timer_q <= timer_q + 1'b1;
            if (pulse_edge && (count_q != 16'hFFFF)) count_q <= count_q + 16'd1;
          end
        end
        default: state_q <= WARM;
      endcase
    end
  end

endmodule
